// File: rtl/serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_seq
// Purpose  : Bit-serial adder. On an accepted Start, A and B are captured
//            and added one bit per clock, LSB first, through a single carry
//            flop. The completed sum and carry are published on Sum/Cout
//            when the last bit is done, and Done pulses one cycle later.
// Ports    : Clk    - rising-edge clock
//            Reset  - asynchronous, active-high reset
//            Start  - begin an addition (accepted only when idle)
//            A, B   - WIDTH-bit operands, captured at the accept edge
//            Sum    - registered (A+B) mod 2^WIDTH
//            Cout   - registered carry-out
//            Busy   - high while bits are being shifted (WIDTH cycles)
//            Done   - one-cycle pulse, Sum/Cout newly valid
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Busy,
  output logic             Done
);

  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_done;

  logic               w_s;
  logic               w_c;
  logic [WIDTH-1:0]   w_acc_next;

  // Full adder on the current operand LSBs and the stored carry.
  assign w_s        = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c        = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (Start) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_done  <= 1'b0;
          r_acc   <= w_acc_next;
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + c_CNT_W'(1);
          if (r_cnt == c_LAST) begin
            // Publish only a complete result; a reset before this edge
            // leaves the previous (or cleared) Sum/Cout in place.
            r_sum   <= w_acc_next;
            r_cout  <= w_c;
            r_state <= DONE;
          end
        end
        DONE: begin
          // Done is registered from the DONE state, so it rises on the
          // edge leaving DONE: WIDTH+1 edges after the accept edge.
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;
  assign Busy = (r_state == SHIFT);
  assign Done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_seq
// Purpose  : Self-checking bench for serial_add_seq (WIDTH=8 and WIDTH=2).
//            Expected results come from plain integer addition; expected
//            Busy/Done/Sum timing is derived from the cycle position
//            relative to the accept edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_seq;

  logic       Clk;
  logic       Reset;

  logic       Start8;
  logic [7:0] A8, B8, Sum8;
  logic       Cout8, Busy8, Done8;

  logic       Start2;
  logic [1:0] A2, B2, Sum2;
  logic       Cout2, Busy2, Done2;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_sum8  = '0;
  logic       exp_cout8 = 1'b0;
  logic [1:0] exp_sum2  = '0;
  logic       exp_cout2 = 1'b0;

  serial_add_seq #(.WIDTH(8)) u_dut8 (
    .Clk(Clk), .Reset(Reset), .Start(Start8), .A(A8), .B(B8),
    .Sum(Sum8), .Cout(Cout8), .Busy(Busy8), .Done(Done8)
  );

  serial_add_seq #(.WIDTH(2)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .Start(Start2), .A(A2), .B(B2),
    .Sum(Sum2), .Cout(Cout2), .Busy(Busy2), .Done(Done2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge. Applies the operands with Start, then
  // watches the WIDTH+2 sample points following the accept edge. Sample i
  // is the negedge after edge i (edge 0 = accept).
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit hold);
    logic [8:0] r;
    logic [7:0] old_s;
    logic       old_c;
    r     = {1'b0, a} + {1'b0, b};
    old_s = exp_sum8;
    old_c = exp_cout8;
    A8 = a; B8 = b; Start8 = 1'b1;
    @(posedge Clk);
    for (int i = 0; i <= 9; i++) begin
      @(negedge Clk);
      chk("busy8", 32'(Busy8), 32'(i < 8));
      chk("done8", 32'(Done8), 32'(i == 9));
      chk("sum8",  32'(Sum8),  (i < 8) ? 32'(old_s) : 32'(r[7:0]));
      chk("cout8", 32'(Cout8), (i < 8) ? 32'(old_c) : 32'(r[8]));
      A8 = 8'($urandom);
      B8 = 8'($urandom);
      if (hold)        Start8 = 1'b1;
      else if (i == 9) Start8 = 1'b0;
      else             Start8 = 1'($urandom);
    end
    exp_sum8  = r[7:0];
    exp_cout8 = r[8];
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] r;
    logic [1:0] old_s;
    logic       old_c;
    r     = {1'b0, a} + {1'b0, b};
    old_s = exp_sum2;
    old_c = exp_cout2;
    A2 = a; B2 = b; Start2 = 1'b1;
    @(posedge Clk);
    for (int i = 0; i <= 3; i++) begin
      @(negedge Clk);
      chk("busy2", 32'(Busy2), 32'(i < 2));
      chk("done2", 32'(Done2), 32'(i == 3));
      chk("sum2",  32'(Sum2),  (i < 2) ? 32'(old_s) : 32'(r[1:0]));
      chk("cout2", 32'(Cout2), (i < 2) ? 32'(old_c) : 32'(r[2]));
      A2 = 2'($urandom);
      B2 = 2'($urandom);
      Start2 = (i == 3) ? 1'b0 : 1'($urandom);
    end
    exp_sum2  = r[1:0];
    exp_cout2 = r[2];
  endtask

  initial begin
    Reset = 1'b1;
    Start8 = 1'b0; A8 = '0; B8 = '0;
    Start2 = 1'b0; A2 = '0; B2 = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    // Reset state
    chk("rst_sum8",  32'(Sum8),  32'h0);
    chk("rst_cout8", 32'(Cout8), 32'h0);
    chk("rst_busy8", 32'(Busy8), 32'h0);
    chk("rst_done8", 32'(Done8), 32'h0);
    chk("rst_sum2",  32'(Sum2),  32'h0);
    chk("rst_busy2", 32'(Busy2), 32'h0);
    Reset = 1'b0;
    @(negedge Clk);

    // Basic additions and carry-out cases
    op8(8'h35, 8'h4A, 1'b0);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hFF, 8'hFF, 1'b0);

    // Idle with Start low: nothing moves
    for (int k = 0; k < 3; k++) begin
      A8 = 8'($urandom); B8 = 8'($urandom);
      @(negedge Clk);
      chk("idle_busy8", 32'(Busy8), 32'h0);
      chk("idle_done8", 32'(Done8), 32'h0);
      chk("idle_sum8",  32'(Sum8),  32'(exp_sum8));
      chk("idle_cout8", 32'(Cout8), 32'(exp_cout8));
    end

    // Start held high continuously: back-to-back operations
    op8(8'h10, 8'h20, 1'b1);
    for (int k = 0; k < 3; k++) op8(8'($urandom), 8'($urandom), 1'b1);
    op8(8'($urandom), 8'($urandom), 1'b0);

    // Reset in the 4th SHIFT cycle aborts with no Done and clears outputs
    @(negedge Clk);
    A8 = 8'hAA; B8 = 8'h55; Start8 = 1'b1;
    @(posedge Clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      Start8 = 1'b0;
      chk("abort_busy_pre", 32'(Busy8), 32'h1);
    end
    Reset = 1'b1;
    #1;
    chk("abort_busy", 32'(Busy8), 32'h0);
    chk("abort_sum",  32'(Sum8),  32'h0);
    chk("abort_cout", 32'(Cout8), 32'h0);
    chk("abort_done", 32'(Done8), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    exp_sum8  = '0;
    exp_cout8 = 1'b0;
    exp_sum2  = '0;
    exp_cout2 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      chk("abort_nodone", 32'(Done8), 32'h0);
      chk("abort_idle",   32'(Busy8), 32'h0);
      chk("abort_nosum",  32'(Sum8),  32'h0);
    end
    op8(8'h01, 8'h02, 1'b0);

    // Previous result held through a following operation
    op8(8'h35, 8'h4A, 1'b0);
    op8(8'h80, 8'h80, 1'b0);

    // Random operations with idle gaps
    for (int k = 0; k < 10; k++) begin
      op8(8'($urandom), 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    // WIDTH=2 instance
    op2(2'd3, 2'd3);
    for (int k = 0; k < 6; k++) op2(2'($urandom), 2'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
